axi4lite_apb_master: RTL
========================

Name: axi4lite_apb_master

Overview:
- Downstream stage of the AXI4-Lite transactor in the APB/AXI4-Lite bridge.
- Acts as an AXI4-Lite slave: consumes the transactor's registered AW/W/AR channels and returns B/R responses.
- Converts each accepted transaction into one APB3/APB4 transfer (SETUP then ACCESS) on a single APB master port.
- One transaction is outstanding at a time; write and read requests are arbitrated round-robin.

Parameters:
- DATAWIDTH, 32, AXI/APB data width; a multiple of 8.
- ADDRWIDTH, 32, AXI/APB address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- awaddr  in  ADDRWIDTH  write address.
- awprot  in  3  write protection.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  DATAWIDTH  write data.
- wstrb  in  DATAWIDTH/8  write byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response accepted.
- araddr  in  ADDRWIDTH  read address.
- arprot  in  3  read protection.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  DATAWIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data accepted.
- paddr  out  ADDRWIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction; 1 = write.
- pwdata  out  DATAWIDTH  APB write data.
- pstrb  out  DATAWIDTH/8  APB write strobes.
- pready  in  1  APB slave ready.
- prdata  in  DATAWIDTH  APB read data.
- pslverr  in  1  APB slave error.

Behaviour:

Reset:
- rst sampled high at a clk edge forces all outputs to 0, clears the AW/W/AR holding registers and the arbitration pointer, and sets state to IDLE.
- This applies mid-transfer too: psel and penable drop on the next edge, and any pending bvalid/rvalid is dropped.

Holding registers (one entry each for AW, W, AR):
- awready = IDLE & AW entry empty. wready = IDLE & W entry empty. arready = IDLE & AR entry empty.
- All ready outputs are registered-free combinational decodes of state and flags; they must not depend on the matching valid.
- A handshake (valid & ready) loads the entry on that edge.
- AW and W may arrive in either order or in the same cycle.

State machine (IDLE, SETUP, ACCESS, WRESP, RRESP):
- IDLE:
  - A write is eligible when the AW and W entries are both full. A read is eligible when the AR entry is full.
  - If only one is eligible, it goes to SETUP.
  - If both are eligible, the one not served last goes. After reset, write wins.
  - Captured fields are driven onto paddr/pprot/pwrite/pwdata/pstrb.
  - pstrb = 0 for reads; pwdata holds its last value for reads.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite, pwdata and pstrb stay stable.
  - Wait while pready=0; there is no timeout.
  - On pready=1: consume the entries and flip the arbitration pointer.
  - Write: bresp = pslverr ? 2'b10 : 2'b00, bvalid=1, go to WRESP.
  - Read: rdata = prdata, rresp = pslverr ? 2'b10 : 2'b00, rvalid=1, go to RRESP.
  - psel and penable drop to 0 on that same edge.
- WRESP: hold bvalid/bresp until bready. On handshake, bvalid=0 and go to IDLE.
- RRESP: hold rvalid/rdata/rresp until rready. On handshake, rvalid=0 and go to IDLE.
- Best-case latency: accept edge N; SETUP at cycle N+1; ACCESS at N+2; response valid at N+3 when pready=1 on the first ACCESS cycle.
- While not IDLE, all readies are 0, so requests are back-pressured.
- Back-to-back transfers need at least one IDLE cycle between them.

Test Plan:
- AW+W in the same cycle, awaddr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=4'hF, pready=1 -> SETUP at +1 (psel=1, penable=0, paddr=0x10, pwrite=1), ACCESS at +2, bvalid=1 with bresp=2'b00 at +3, cleared one cycle after bready.
- W arrives 3 cycles before AW -> no psel until AW is accepted; then the same SETUP/ACCESS sequence with the held wdata.
- Read araddr=0x24, pready low for 4 ACCESS cycles, then prdata=0x1234_5678 with pslverr=1 -> penable held for 5 cycles, rdata=0x1234_5678, rresp=2'b10.
- Write and read eligible simultaneously, twice in a row -> order is write, read, write, read (round-robin); pstrb=0 on the reads.
- rready held low for 10 cycles -> rvalid/rdata stable for all 10; arready/awready/wready stay 0 throughout.
- rst asserted during ACCESS -> next edge psel=penable=0, all valid/ready outputs 0, state IDLE; a subsequent write completes normally.

Source files
------------

// File: rtl/axi4lite_apb_master.sv
// AXI4-Lite slave front end that turns each accepted write or read into a
// single APB3/APB4 transfer (SETUP then ACCESS). One transaction is in flight
// at a time. Writes and reads are arbitrated round-robin.
//
// Handshake semantics (all AXI channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. Ready never depends on the matching
// valid. A valid, once raised, is held with stable payload until that edge.
module axi4lite_apb_master #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   // write address channel
   input  logic [ADDRWIDTH-1:0]     awaddr,
   input  logic [2:0]               awprot,
   input  logic                     awvalid,
   output logic                     awready,
   // write data channel
   input  logic [DATAWIDTH-1:0]     wdata,
   input  logic [DATAWIDTH/8-1:0]   wstrb,
   input  logic                     wvalid,
   output logic                     wready,
   // write response channel
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   // read address channel
   input  logic [ADDRWIDTH-1:0]     araddr,
   input  logic [2:0]               arprot,
   input  logic                     arvalid,
   output logic                     arready,
   // read data channel
   output logic [DATAWIDTH-1:0]     rdata,
   output logic [1:0]               rresp,
   output logic                     rvalid,
   input  logic                     rready,
   // APB master port
   output logic [ADDRWIDTH-1:0]     paddr,
   output logic [2:0]               pprot,
   output logic                     psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [DATAWIDTH-1:0]     pwdata,
   output logic [DATAWIDTH/8-1:0]   pstrb,
   input  logic                     pready,
   input  logic [DATAWIDTH-1:0]     prdata,
   input  logic                     pslverr
);

   localparam int STRBWIDTH = DATAWIDTH / 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      WRESP  = 3'd3,
      RRESP  = 3'd4
   } state_t;

   state_t                 state;

   // one-entry holding registers per request channel
   logic                   aw_full;
   logic [ADDRWIDTH-1:0]   aw_addr;
   logic [2:0]             aw_prot;
   logic                   w_full;
   logic [DATAWIDTH-1:0]   w_data;
   logic [STRBWIDTH-1:0]   w_strb;
   logic                   ar_full;
   logic [ADDRWIDTH-1:0]   ar_addr;
   logic [2:0]             ar_prot;

   // 1 = a read gets priority when both directions are eligible
   logic                   prio_read;

   logic                   wr_elig;
   logic                   rd_elig;
   logic                   pick_write;
   logic                   is_idle;

   assign is_idle    = (state == IDLE);
   assign wr_elig    = aw_full & w_full;
   assign rd_elig    = ar_full;
   assign pick_write = wr_elig & (~rd_elig | ~prio_read);

   // Readies are decoded from state and entry flags only; held low while rst
   // is asserted so every output reads 0 during reset.
   assign awready = ~rst & is_idle & ~aw_full;
   assign wready  = ~rst & is_idle & ~w_full;
   assign arready = ~rst & is_idle & ~ar_full;

   // Request capture, arbitration, APB sequencing and AXI responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         aw_full   <= 1'b0;
         aw_addr   <= '0;
         aw_prot   <= '0;
         w_full    <= 1'b0;
         w_data    <= '0;
         w_strb    <= '0;
         ar_full   <= 1'b0;
         ar_addr   <= '0;
         ar_prot   <= '0;
         prio_read <= 1'b0;
         paddr     <= '0;
         pprot     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         bresp     <= '0;
         bvalid    <= 1'b0;
         rdata     <= '0;
         rresp     <= '0;
         rvalid    <= 1'b0;
      end else begin
         // loads only happen in IDLE, so they never collide with the
         // entry release in ACCESS below
         if (awvalid && awready) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr;
            aw_prot <= awprot;
         end
         if (wvalid && wready) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (arvalid && arready) begin
            ar_full <= 1'b1;
            ar_addr <= araddr;
            ar_prot <= arprot;
         end

         case (state)
            IDLE: begin
               if (pick_write) begin
                  paddr  <= aw_addr;
                  pprot  <= aw_prot;
                  pwrite <= 1'b1;
                  pwdata <= w_data;
                  pstrb  <= w_strb;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end else if (rd_elig) begin
                  // pwdata keeps its previous value on reads
                  paddr  <= ar_addr;
                  pprot  <= ar_prot;
                  pwrite <= 1'b0;
                  pstrb  <= '0;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  // the direction just served loses the next tie
                  prio_read <= pwrite;
                  if (pwrite) begin
                     aw_full <= 1'b0;
                     w_full  <= 1'b0;
                     bresp   <= pslverr ? 2'b10 : 2'b00;
                     bvalid  <= 1'b1;
                     state   <= WRESP;
                  end else begin
                     ar_full <= 1'b0;
                     rdata   <= prdata;
                     rresp   <= pslverr ? 2'b10 : 2'b00;
                     rvalid  <= 1'b1;
                     state   <= RRESP;
                  end
               end
            end
            WRESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            RRESP: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
